// File: rtl/counter.sv
// MM:SS stopwatch time base: a prescaler divides clk down to one tick per TICK_DIV edges, and a BCD chain counts 00:00..99:59.
// Digits update on the tick edge straight from flops; there is no enable or stall, so the count runs whenever rst is high.
module counter #(
    parameter int unsigned TICK_DIV = 100000000,
    parameter int unsigned DIV_W    = 32
) (
    input  logic       clk,
    input  logic       rst,
    output logic [3:0] minutes_top_digit,
    output logic [3:0] minutes_bot_digit,
    output logic [3:0] seconds_top_digit,
    output logic [3:0] seconds_bot_digit
);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(TICK_DIV - 1);

    logic [DIV_W-1:0] r_div;
    logic [3:0]       r_sec_bot;
    logic [3:0]       r_sec_top;
    logic [3:0]       r_min_bot;
    logic [3:0]       r_min_top;

    logic w_tick;
    logic w_c0;
    logic w_c1;
    logic w_c2;

    // Wrap compares use >= so an out-of-range digit recovers to 0 the next time it advances.
    assign w_tick = (r_div == LAST);
    assign w_c0   = w_tick && (r_sec_bot >= 4'd9);
    assign w_c1   = w_c0   && (r_sec_top >= 4'd5);
    assign w_c2   = w_c1   && (r_min_bot >= 4'd9);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div     <= '0;
            r_sec_bot <= 4'd0;
            r_sec_top <= 4'd0;
            r_min_bot <= 4'd0;
            r_min_top <= 4'd0;
        end else begin
            r_div <= w_tick ? '0 : r_div + DIV_W'(1);
            if (w_tick) r_sec_bot <= w_c0 ? 4'd0 : r_sec_bot + 4'd1;
            if (w_c0)   r_sec_top <= w_c1 ? 4'd0 : r_sec_top + 4'd1;
            if (w_c1)   r_min_bot <= w_c2 ? 4'd0 : r_min_bot + 4'd1;
            if (w_c2)   r_min_top <= (r_min_top >= 4'd9) ? 4'd0 : r_min_top + 4'd1;
        end
    end

    assign minutes_top_digit = r_min_top;
    assign minutes_bot_digit = r_min_bot;
    assign seconds_top_digit = r_sec_top;
    assign seconds_bot_digit = r_sec_bot;

endmodule

// File: tb/tb_counter.sv
// Directed bench for counter: one instance with TICK_DIV=4 for reset and prescale latency,
// one with TICK_DIV=1 for carries, wrap-around and digit range over 7000 seconds.
module tb_counter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a;
    logic rst_b;
    logic [3:0] a_mt, a_mb, a_st, a_sb;
    logic [3:0] b_mt, b_mb, b_st, b_sb;

    int n_checks = 0;
    int n_errors = 0;

    counter #(.TICK_DIV(4), .DIV_W(3)) u_div4 (
        .clk               (clk),
        .rst               (rst_a),
        .minutes_top_digit (a_mt),
        .minutes_bot_digit (a_mb),
        .seconds_top_digit (a_st),
        .seconds_bot_digit (a_sb)
    );

    counter #(.TICK_DIV(1), .DIV_W(1)) u_div1 (
        .clk               (clk),
        .rst               (rst_b),
        .minutes_top_digit (b_mt),
        .minutes_bot_digit (b_mb),
        .seconds_top_digit (b_st),
        .seconds_bot_digit (b_sb)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected display {MT,MB,ST,SB} after n seconds, modulo 100 minutes.
    function automatic logic [15:0] mmss(input int n);
        int s, mm, ss;
        s  = n % 6000;
        mm = s / 60;
        ss = s % 60;
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
    endfunction

    initial begin
        logic ok;
        rst_a = 1'b0;
        rst_b = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check("rst_a", {a_mt, a_mb, a_st, a_sb}, 16'h0000);
        check("rst_b", {b_mt, b_mb, b_st, b_sb}, 16'h0000);

        // Release on a negedge so the next rising edge is edge 1.
        rst_a = 1'b1;
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("a_pre@%0d", k), {a_mt, a_mb, a_st, a_sb}, mmss(k / 4));
        end

        @(posedge clk);
        #2 rst_a = 1'b0;
        #1 check("a_async_rst", {a_mt, a_mb, a_st, a_sb}, 16'h0000);
        @(negedge clk);
        check("a_rst_hold", {a_mt, a_mb, a_st, a_sb}, 16'h0000);

        rst_b = 1'b1;
        for (int n = 1; n <= 7000; n++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("b_seq@%0d", n), {b_mt, b_mb, b_st, b_sb}, mmss(n));
            ok = (b_st <= 4'd5) && (b_sb <= 4'd9) && (b_mb <= 4'd9) && (b_mt <= 4'd9);
            check($sformatf("b_range@%0d", n), 16'(ok), 16'd1);
        end

        rst_b = 1'b0;
        #1 check("b_async_rst", {b_mt, b_mb, b_st, b_sb}, 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/counter.md
Name: counter

Overview:
- Free-running MM:SS stopwatch time base for the stopwatch design.
- Divides the system clock down to a 1 Hz tick and advances a four-digit BCD minutes/seconds count.
- Digit outputs feed the downstream display/multiplexing logic.

Parameters:
- TICK_DIV, 100000000: clk cycles per count step (1 s at 100 MHz). Legal range 1 to 2^32-1. Benches override it with small values.
- DIV_W, 32: width of the prescaler counter. Must satisfy 2^DIV_W > TICK_DIV-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-low reset. rst=0 clears all state immediately; release is sampled on clk.
- minutes_top_digit  output  4  BCD tens of minutes, 0-9.
- minutes_bot_digit  output  4  BCD units of minutes, 0-9.
- seconds_top_digit  output  4  BCD tens of seconds, 0-5.
- seconds_bot_digit  output  4  BCD units of seconds, 0-9.

Behaviour:
- Reset (rst=0, asynchronous):
  - Prescaler = 0.
  - All four digits = 0, so the display reads 00:00.
  - This holds regardless of clk, and applies mid-count as well: the count returns to 00:00 immediately.
- Prescaler:
  - Counts 0 .. TICK_DIV-1 on each rising clk edge while rst=1.
  - At TICK_DIV-1 it wraps to 0, and that edge is a tick edge.
  - With TICK_DIV=1, every edge is a tick edge.
- On a tick edge the BCD chain advances by one second:
  - seconds_bot: 0..8 increments; 9 goes to 0 and carries.
  - seconds_top: increments on carry; 5 with carry goes to 0 and carries. 59 s rolls to the next minute.
  - minutes_bot: increments on carry; 9 with carry goes to 0 and carries.
  - minutes_top: increments on carry; 9 with carry goes to 0 (no further carry).
  - 99:59 rolls over to 00:00. There is no overflow flag and no saturation.
- Non-tick edges: digits hold their value.
- Timing:
  - All outputs are registered and driven directly from flops, with no combinational path from inputs.
  - First increment (00:00 to 00:01) occurs on the TICK_DIV-th rising edge after rst deasserts. Each subsequent increment occurs every TICK_DIV edges.
  - All digits change on the same edge as the tick.
- Invariants:
  - Digits never leave their legal ranges: seconds_top never exceeds 5, and the others never exceed 9.
  - Illegal states are unreachable from reset. If one occurs anyway, the digit falls back to 0 on the next tick it participates in.
- No enable, pause or load: the count runs continuously whenever rst=1.

Test Plan:
- Reset: TICK_DIV=4, hold rst=0 for 5 edges -> all digits 0. Assert rst=0 asynchronously between edges mid-count -> digits read 0 before the next edge.
- Prescale latency: TICK_DIV=4, release rst -> digits stay 00:00 for edges 1-3 and read 00:01 at edge 4, 00:02 at edge 8.
- Seconds carry: TICK_DIV=1, run 10 edges -> 00:10. Run 60 edges total -> 01:00, with seconds_top never exceeding 5.
- Minutes carry: TICK_DIV=1, run 600 edges -> 10:00. Run 5999 edges -> 99:59.
- Wrap-around: TICK_DIV=1, run 6000 edges -> 00:00. Run 6001 edges -> 00:01.
- Range check: TICK_DIV=1, run 7000 edges with an assertion every cycle -> each digit stays within its legal BCD range, and each increment matches a reference seconds-count modulo 6000.
